div_seq_ctrl: RTL

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential 32-bit divider for div/divu.
// Restoring algorithm, one quotient bit per cycle, fixed 32-cycle iteration.
// Signed operands are reduced to magnitudes on acceptance; signs are reapplied on entry to DONE.
module div_seq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_req,
    input  logic        div_signed,
    input  logic [31:0] div_src1,
    input  logic [31:0] div_src2,
    input  logic        flush,
    input  logic        res_ack,
    output logic        div_busy,
    output logic        div_done,
    output logic [31:0] div_quot,
    output logic [31:0] div_rem
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;     // dividend magnitude, consumed MSB first by shifting left
    logic [31:0] dvs_q;     // divisor magnitude
    logic [31:0] prem_q;    // kept partial remainder; always fits 32 bits
    logic [31:0] quo_q;     // quotient magnitude being assembled
    logic        qsign_q;
    logic        rsign_q;

    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic        trial_ok;
    logic [31:0] prem_nxt;
    logic [31:0] quo_nxt;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic        unused_trial;

    // Operand magnitudes; 0x80000000 maps onto itself, which is the correct magnitude.
    always_comb begin
        abs1 = (div_signed && div_src1[31]) ? (~div_src1 + 32'd1) : div_src1;
        abs2 = (div_signed && div_src2[31]) ? (~div_src2 + 32'd1) : div_src2;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted  = {prem_q, dvd_q[31]};
        trial    = {1'b0, shifted} - {2'b00, dvs_q};
        trial_ok = ~trial[33];
        // A kept difference is below the divisor, so bit 32 is always zero when kept.
        prem_nxt = trial_ok ? trial[31:0] : shifted[31:0];
        quo_nxt  = {quo_q[30:0], trial_ok};
        quot_fix = qsign_q ? (~quo_nxt + 32'd1) : quo_nxt;
        rem_fix  = rsign_q ? (~prem_nxt + 32'd1) : prem_nxt;
    end

    assign unused_trial = trial[32];

    // Status flags decode directly from the state register.
    always_comb begin
        div_busy = (state_q != StIdle);
        div_done = (state_q == StDone);
    end

    // Control FSM and datapath registers; flush outranks res_ack and div_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 5'd0;
            dvd_q    <= 32'd0;
            dvs_q    <= 32'd0;
            prem_q   <= 32'd0;
            quo_q    <= 32'd0;
            qsign_q  <= 1'b0;
            rsign_q  <= 1'b0;
            div_quot <= 32'd0;
            div_rem  <= 32'd0;
        end else if (flush) begin
            state_q <= StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (div_req) begin
                        state_q <= StCalc;
                        cnt_q   <= 5'd0;
                        dvd_q   <= abs1;
                        dvs_q   <= abs2;
                        prem_q  <= 32'd0;
                        quo_q   <= 32'd0;
                        qsign_q <= div_signed & (div_src1[31] ^ div_src2[31]);
                        rsign_q <= div_signed & div_src1[31];
                    end
                end
                StCalc: begin
                    prem_q <= prem_nxt;
                    quo_q  <= quo_nxt;
                    dvd_q  <= {dvd_q[30:0], 1'b0};
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q  <= StDone;
                        div_quot <= quot_fix;
                        div_rem  <= rem_fix;
                    end
                end
                StDone: begin
                    if (res_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
